// File: rtl/jt900h_prefetch.sv
// JT900H instruction prefetch queue: 16-bit bus fetches ahead of the PC into a
// byte FIFO, exposing the next four bytes to the decoder and owning the PC.
module jt900h_prefetch #(
    parameter int unsigned QBYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        pc_ld,
    input  logic [23:0] pc_din,
    input  logic [2:0]  cons,
    output logic [23:0] pc,
    output logic [31:0] q_data,
    output logic [3:0]  q_cnt,
    output logic        q_under,
    output logic        bus_req,
    output logic [23:0] bus_addr,
    input  logic        bus_ack,
    input  logic [15:0] bus_din
);

    localparam int unsigned AW = $clog2(QBYTES);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t         state_q, state_d;
    logic [23:0]    pc_q, pc_d;
    logic [23:0]    fa_q, fa_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [7:0]     mem_q [QBYTES];
    logic [7:0]     mem_d [QBYTES];
    logic           under_q, under_d;
    logic           req_q, req_d;
    logic [23:0]    addr_q, addr_d;

    logic           legal;
    logic [2:0]     pop;
    logic [1:0]     added;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fa_d    = fa_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mem_d   = mem_q;
        under_d = 1'b0;
        req_d   = req_q;
        addr_d  = addr_q;
        pop     = '0;
        added   = '0;
        legal   = (cons <= 3'd4) && ({1'b0, cons} <= cnt_q);

        if (pc_ld) begin
            // Flush wins over consume/enqueue; an in-flight read must still complete on the bus.
            pc_d  = pc_din;
            fa_d  = pc_din;
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            if (state_q != IDLE) begin
                if (bus_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end
        end else begin
            if (legal) begin
                pop  = cons;
                rd_d = rd_q + AW'(cons);
                pc_d = pc_q + 24'(cons);
            end else begin
                under_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (32'(cnt_q) + 32'd2 <= QBYTES) begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        addr_d  = {fa_q[23:1], 1'b0};
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        if (fa_q[0]) begin
                            mem_d[wr_q] = bus_din[15:8];
                            wr_d        = wr_q + AW'(1);
                            fa_d        = fa_q + 24'd1;
                            added       = 2'd1;
                        end else begin
                            mem_d[wr_q]          = bus_din[7:0];
                            mem_d[wr_q + AW'(1)] = bus_din[15:8];
                            wr_d                 = wr_q + AW'(2);
                            fa_d                 = fa_q + 24'd2;
                            added                = 2'd2;
                        end
                    end
                end
                DROP: begin
                    if (bus_ack) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            cnt_d = cnt_q - 4'(pop) + 4'(added);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            fa_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            for (int unsigned i = 0; i < QBYTES; i++) mem_q[i] <= '0;
            under_q <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else if (cen) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fa_q    <= fa_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mem_q   <= mem_d;
            under_q <= under_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        q_data = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < 32'(cnt_q)) q_data[8*i +: 8] = mem_q[rd_q + AW'(i)];
        end
    end

    assign pc       = pc_q;
    assign q_cnt    = cnt_q;
    assign q_under  = under_q;
    assign bus_req  = req_q;
    assign bus_addr = addr_q;

endmodule

// File: tb/tb_jt900h_prefetch.sv
// Directed bench for jt900h_prefetch: vector table plus multi-cycle sequences
// for drain, flush-while-busy and address wrap.
module tb_jt900h_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        pc_ld = 1'b0;
    logic [23:0] pc_din = '0;
    logic [2:0]  cons = '0;
    logic [23:0] pc;
    logic [31:0] q_data;
    logic [3:0]  q_cnt;
    logic        q_under;
    logic        bus_req;
    logic [23:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_din = '0;

    jt900h_prefetch #(.QBYTES(8)) dut (
        .clk(clk), .rst(rst), .cen(cen), .pc_ld(pc_ld), .pc_din(pc_din),
        .cons(cons), .pc(pc), .q_data(q_data), .q_cnt(q_cnt), .q_under(q_under),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_din(bus_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cen;
        logic        ld;
        logic [23:0] ldv;
        logic [2:0]  cons;
        logic        ack;
        logic [15:0] din;
        logic [23:0] e_pc;
        logic [3:0]  e_cnt;
        logic [31:0] e_data;
        logic        e_under;
        logic        e_req;
        logic [23:0] e_addr;
    } vec_t;

    vec_t vecs [25];

    int n_pass  = 0;
    int n_total = 0;
    bit auto_bus = 1'b0;
    int n_log = 0;
    logic [23:0] alog [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock; in auto mode the bus acks immediately with {addr+1, addr} bytes.
    task automatic cyc();
        logic [7:0] a;
        if (auto_bus && bus_req) begin
            a = bus_addr[7:0];
            bus_ack = 1'b1;
            bus_din = {a + 8'd1, a};
            if (n_log < 4) begin
                alog[n_log] = bus_addr;
                n_log++;
            end
        end
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        pc_ld   = 1'b0;
    endtask

    // Auto-bus data makes every valid byte equal to its own address low byte.
    task automatic chk_bytes(input string name);
        logic [31:0] e;
        logic [23:0] p;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            p = pc + 24'(i);
            if (i < int'(q_cnt)) e[8*i +: 8] = p[7:0];
        end
        chk(name, q_data, e);
    endtask

    task automatic ack_cyc(input logic [15:0] d);
        bus_ack = 1'b1;
        bus_din = d;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pc0;
        logic [3:0]  c0;
        logic        r0, lg;
        logic [3:0]  ec;

        //            cen ld ldv        cons ack din       e_pc       cnt data          un req addr
        vecs[0]  = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h000000, 0, 32'h00000000, 0, 1, 24'h000000};
        vecs[1]  = '{1, 0, 24'h0,     0, 1, 16'h0100, 24'h000000, 2, 32'h00000100, 0, 0, 24'h000000};
        vecs[2]  = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h000000, 2, 32'h00000100, 0, 1, 24'h000002};
        vecs[3]  = '{1, 0, 24'h0,     0, 1, 16'h0302, 24'h000000, 4, 32'h03020100, 0, 0, 24'h000002};
        vecs[4]  = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h000000, 4, 32'h03020100, 0, 1, 24'h000004};
        vecs[5]  = '{1, 0, 24'h0,     0, 1, 16'h0504, 24'h000000, 6, 32'h03020100, 0, 0, 24'h000004};
        vecs[6]  = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h000000, 6, 32'h03020100, 0, 1, 24'h000006};
        vecs[7]  = '{1, 0, 24'h0,     0, 1, 16'h0706, 24'h000000, 8, 32'h03020100, 0, 0, 24'h000006};
        vecs[8]  = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h000000, 8, 32'h03020100, 0, 0, 24'h000006};
        vecs[9]  = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h000000, 8, 32'h03020100, 0, 0, 24'h000006};
        vecs[10] = '{1, 1, 24'h001235,0, 0, 16'h0,    24'h001235, 0, 32'h00000000, 0, 0, 24'h000006};
        vecs[11] = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h001235, 0, 32'h00000000, 0, 1, 24'h001234};
        vecs[12] = '{1, 0, 24'h0,     0, 1, 16'h3534, 24'h001235, 1, 32'h00000035, 0, 0, 24'h001234};
        vecs[13] = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h001235, 1, 32'h00000035, 0, 1, 24'h001236};
        vecs[14] = '{1, 0, 24'h0,     0, 1, 16'h3736, 24'h001235, 3, 32'h00373635, 0, 0, 24'h001236};
        vecs[15] = '{1, 0, 24'h0,     2, 0, 16'h0,    24'h001237, 1, 32'h00000037, 0, 1, 24'h001238};
        vecs[16] = '{1, 0, 24'h0,     2, 0, 16'h0,    24'h001237, 1, 32'h00000037, 1, 1, 24'h001238};
        vecs[17] = '{1, 0, 24'h0,     0, 1, 16'h3938, 24'h001237, 3, 32'h00393837, 0, 0, 24'h001238};
        vecs[18] = '{1, 0, 24'h0,     5, 0, 16'h0,    24'h001237, 3, 32'h00393837, 1, 1, 24'h00123A};
        vecs[19] = '{1, 0, 24'h0,     4, 0, 16'h0,    24'h001237, 3, 32'h00393837, 1, 1, 24'h00123A};
        vecs[20] = '{1, 0, 24'h0,     3, 1, 16'h3B3A, 24'h00123A, 2, 32'h00003B3A, 0, 0, 24'h00123A};
        vecs[21] = '{1, 0, 24'h0,     2, 0, 16'h0,    24'h00123C, 0, 32'h00000000, 0, 1, 24'h00123C};
        vecs[22] = '{1, 0, 24'h0,     0, 0, 16'h0,    24'h00123C, 0, 32'h00000000, 0, 1, 24'h00123C};
        vecs[23] = '{0, 0, 24'h0,     1, 1, 16'h1234, 24'h00123C, 0, 32'h00000000, 0, 1, 24'h00123C};
        vecs[24] = '{1, 0, 24'h0,     0, 1, 16'h3D3C, 24'h00123C, 2, 32'h00003D3C, 0, 0, 24'h00123C};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_cnt", 32'(q_cnt), 32'h0);
        chk("rst_data", q_data, 32'h0);
        chk("rst_req", 32'(bus_req), 32'h0);
        chk("rst_addr", 32'(bus_addr), 32'h0);
        chk("rst_under", 32'(q_under), 32'h0);

        for (int i = 0; i < 25; i++) begin
            cen     = vecs[i].cen;
            pc_ld   = vecs[i].ld;
            pc_din  = vecs[i].ldv;
            cons    = vecs[i].cons;
            bus_ack = vecs[i].ack;
            bus_din = vecs[i].din;
            cyc();
            cen = 1'b1;
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
            chk($sformatf("v%0d_cnt", i), 32'(q_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_data", i), q_data, vecs[i].e_data);
            chk($sformatf("v%0d_under", i), 32'(q_under), 32'(vecs[i].e_under));
            chk($sformatf("v%0d_req", i), 32'(bus_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), 32'(bus_addr), 32'(vecs[i].e_addr));
        end
        cons = '0;

        // Fill from 0, then drain with cons=3 every cycle while the bus refills.
        pc_ld = 1'b1; pc_din = 24'h0;
        cyc();
        auto_bus = 1'b1;
        for (int k = 0; k < 40 && !(q_cnt == 4'd8 && !bus_req); k++) cyc();
        chk("fill_cnt", 32'(q_cnt), 32'd8);
        chk("fill_data", q_data, 32'h03020100);
        repeat (3) cyc();
        chk("fill_noreq", 32'(bus_req), 32'h0);
        cons = 3'd3;
        for (int k = 0; k < 8; k++) begin
            pc0 = pc; c0 = q_cnt; r0 = bus_req;
            cyc();
            lg = (c0 >= 4'd3);
            ec = c0 - (lg ? 4'd3 : 4'd0) + (r0 ? 4'd2 : 4'd0);
            chk($sformatf("drain%0d_pc", k), 32'(pc), 32'(lg ? pc0 + 24'd3 : pc0));
            chk($sformatf("drain%0d_cnt", k), 32'(q_cnt), 32'(ec));
            chk($sformatf("drain%0d_under", k), 32'(q_under), 32'(!lg));
            chk($sformatf("drain%0d_req", k), 32'(bus_req), 32'(r0 ? 1'b0 : (c0 <= 4'd6)));
            chk_bytes($sformatf("drain%0d_data", k));
        end
        cons = '0;
        for (int k = 0; k < 40 && !(q_cnt == 4'd8 && !bus_req); k++) cyc();
        chk("refill_cnt", 32'(q_cnt), 32'd8);
        auto_bus = 1'b0;

        // Flush with a read outstanding: the late data must be dropped.
        pc_ld = 1'b1; pc_din = 24'h000100;
        cyc();
        chk("d0_cnt", 32'(q_cnt), 32'h0);
        cyc();
        chk("d1_req", 32'(bus_req), 32'h1);
        chk("d1_addr", 32'(bus_addr), 32'h000100);
        pc_ld = 1'b1; pc_din = 24'h000201;
        cyc();
        chk("d2_pc", 32'(pc), 32'h000201);
        chk("d2_req", 32'(bus_req), 32'h1);
        chk("d2_addr", 32'(bus_addr), 32'h000100);
        cyc();
        pc_ld = 1'b1; pc_din = 24'h000301;
        cyc();
        chk("d3_pc", 32'(pc), 32'h000301);
        chk("d3_req", 32'(bus_req), 32'h1);
        chk("d3_addr", 32'(bus_addr), 32'h000100);
        chk("d3_cnt", 32'(q_cnt), 32'h0);
        ack_cyc(16'hABCD);
        chk("d4_req", 32'(bus_req), 32'h0);
        chk("d4_cnt", 32'(q_cnt), 32'h0);
        chk("d4_data", q_data, 32'h0);
        cyc();
        chk("d5_req", 32'(bus_req), 32'h1);
        chk("d5_addr", 32'(bus_addr), 32'h000300);
        ack_cyc(16'h0100);
        chk("d6_cnt", 32'(q_cnt), 32'h1);
        chk("d6_data", q_data, 32'h00000001);
        cyc();
        chk("d7_addr", 32'(bus_addr), 32'h000302);
        pc_ld = 1'b1; pc_din = 24'h000500;
        ack_cyc(16'h0302);
        chk("d8_req", 32'(bus_req), 32'h0);
        chk("d8_cnt", 32'(q_cnt), 32'h0);
        chk("d8_pc", 32'(pc), 32'h000500);
        cyc();
        chk("d9_req", 32'(bus_req), 32'h1);
        chk("d9_addr", 32'(bus_addr), 32'h000500);
        ack_cyc(16'h0100);
        chk("d10_cnt", 32'(q_cnt), 32'h2);
        chk("d10_data", q_data, 32'h00000100);

        // Address wrap at the top of the 24-bit space.
        pc_ld = 1'b1; pc_din = 24'hFFFFFE;
        cyc();
        n_log = 0;
        auto_bus = 1'b1;
        for (int k = 0; k < 20 && q_cnt < 4'd4; k++) cyc();
        chk("w_cnt", 32'(q_cnt >= 4'd4), 32'h1);
        chk("w_addr0", 32'(alog[0]), 32'hFFFFFE);
        chk("w_addr1", 32'(alog[1]), 32'h000000);
        chk("w_data", q_data, 32'h0100FFFE);
        chk("w_pc", 32'(pc), 32'hFFFFFE);
        cons = 3'd2;
        cyc();
        cons = '0;
        chk("w_pc2", 32'(pc), 32'h000000);
        chk("w_data2", 32'(q_data[15:0]), 32'h0100);
        auto_bus = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jt900h_prefetch.md
Name: jt900h_prefetch

Overview:
Instruction byte prefetch queue and fetch sequencer for the JT900H CPU. It issues 16-bit bus reads ahead of the program counter and stores opcode and operand bytes in a byte FIFO. The decoder sees the next four bytes at once, consumes 0-4 bytes per cycle, and can redirect the PC on jumps. It feeds the md/opcode latch path of the register file and owns the architectural PC.

Parameters:
QBYTES, 8, queue depth in bytes (power of two, >=4)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cen  input  1  clock enable; all state advances only when cen=1
pc_ld  input  1  load new PC and flush queue
pc_din  input  24  new PC value for pc_ld
cons  input  3  bytes consumed this cycle (0-4; values 5-7 are illegal)
pc  output  24  address of the byte at q_data[7:0]
q_data  output  32  next four queued bytes, byte at pc in [7:0]; invalid bytes read 0
q_cnt  output  4  bytes valid in queue (0..QBYTES)
q_under  output  1  one-cycle pulse: cons > q_cnt, or cons > 4
bus_req  output  1  read request
bus_addr  output  24  word-aligned read address, bit0 always 0
bus_ack  input  1  one-cycle strobe; bus_din valid this cycle
bus_din  input  16  read data, little endian

Behaviour:
- Reset: pc=0, internal fetch address fa=0, q_cnt=0, q_data=0, bus_req=0, bus_addr=0, q_under=0, state IDLE.
- States: IDLE (no request), BUSY (request outstanding), DROP (request outstanding, data to be discarded).
- IDLE->BUSY when QBYTES-q_cnt >= 2 and no pc_ld this cycle. Set bus_req=1, bus_addr={fa[23:1],0}.
- bus_req and bus_addr stay constant until the bus_ack cycle. bus_req drops on the cycle after ack.
- BUSY + bus_ack with fa even: enqueue bus_din[7:0] then bus_din[15:8] (2 bytes), fa+=2.
- BUSY + bus_ack with fa odd: enqueue bus_din[15:8] only, fa+=1. Then go to IDLE.
- Back-to-back fetches are allowed: IDLE re-evaluates the space check on the next cycle. Minimum 2 cycles per request.
- Consume: if cons<=q_cnt and cons<=4, pop cons bytes, pc+=cons mod 2^24.
- Illegal consume: otherwise pop nothing, pc unchanged, q_under=1 for one cycle.
- Enqueue and consume in the same cycle: q_cnt_next = q_cnt - cons + added. The space check uses the pre-consume q_cnt.
- q_cnt never exceeds QBYTES.
- pc_ld has priority over consume and enqueue in the same cycle:
  - q_cnt=0, pc=fa=pc_din, q_data reads 0.
  - If a request is outstanding (BUSY, or bus_ack not yet seen), go to DROP. bus_req and bus_addr hold until bus_ack, and the returned data is discarded. Then go to IDLE.
  - If bus_ack arrives in the same cycle as pc_ld, the data is discarded and the state goes to IDLE.
- pc_ld while in DROP: update pc/fa again and stay in DROP.
- cen=0: no state change, bus_ack ignored. The bus master must hold ack until a cen cycle.
- Addresses wrap modulo 2^24: fa=FFFFFE fetches 2 bytes, then fa=000000.
- q_data: byte i = queue entry i if i<q_cnt, else 0. Combinational from queue registers and read pointer.
- Queue is a circular buffer with read/write pointers of log2(QBYTES) bits plus a count register.

Test Plan:
- Reset, then run with cons=0 and bus returning addr-derived data (din={addr[7:0]+1,addr[7:0]}) -> reads at 000000,000002,000004,000006; q_cnt settles at 8; q_data=03020100; no 5th request.
- pc_ld pc_din=001235, cons=0 -> first bus_addr=001234, only byte 35 queued, then bus_addr=001236; pc=001235, q_data[7:0]=35, q_cnt=1 then 3.
- Queue full (8) plus cons=3 every cycle -> pc advances by 3 per cycle; a new request is issued when pre-consume q_cnt<=6; q_under stays 0 until the queue runs dry.
- q_cnt=1, cons=2 -> q_under pulse, pc and q_cnt unchanged.
- pc_ld during an outstanding request, ack 3 cycles later with din=ABCD -> ABCD not queued; bus_req holds until ack; next request at the new word-aligned pc; q_cnt=0 in between.
- pc_ld pc_din=FFFFFE -> requests at FFFFFE then 000000; q_data byte order correct across the wrap; pc wraps to 000000 after cons=2.
